// File: rtl/ex_stage.sv
// RV32IC execute stage: operand forwarding, ALU, branch/jump resolution, load-use
// detection and the registered EX/MEM record plus one-cycle front-end redirect.
package ex_stage_pkg;
   typedef struct packed {
      logic [31:0] pc;
      logic [2:0]  func3;
      logic [6:0]  func7;
      logic [2:0]  alu_op;
      logic [31:0] immediate;
      logic [4:0]  rd;
      logic [1:0]  alu_src;
      logic        mem2reg;
      logic        reg_write;
      logic        branch;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        mem_read;
      logic        mem_write;
   } ex_state_t;
endpackage

module ex_stage
   import ex_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  ex_state_t   ex_state,
   input  logic        ex_ilen16,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  logic        wb_we,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   input  logic        mem_stall,
   output logic        ex_stall,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        mem_valid,
   output logic [31:0] mem_pc,
   output logic [31:0] mem_alu_result,
   output logic [31:0] mem_store_data,
   output logic [4:0]  mem_rd,
   output logic [2:0]  mem_func3,
   output logic        mem_mem_read,
   output logic        mem_mem_write,
   output logic        mem_mem2reg,
   output logic        mem_regwrite
);
   localparam int unsigned XLEN = 32;
   localparam int unsigned RW   = 5;

   logic            mem_valid_q, mem_valid_d;
   logic [XLEN-1:0] mem_pc_q, mem_pc_d, mem_alu_result_q, mem_alu_result_d;
   logic [XLEN-1:0] mem_store_data_q, mem_store_data_d;
   logic [RW-1:0]   mem_rd_q, mem_rd_d;
   logic [2:0]      mem_func3_q, mem_func3_d;
   logic            mem_mem_read_q, mem_mem_read_d, mem_mem_write_q, mem_mem_write_d;
   logic            mem_mem2reg_q, mem_mem2reg_d, mem_regwrite_q, mem_regwrite_d;
   logic            redirect_valid_q, redirect_valid_d;
   logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

   logic [XLEN-1:0] rs1_fwd, rs2_fwd, op1, op2, alu_res, link, target;
   logic [4:0]      shamt;
   logic            mem_fwd_ok, hazard, kill, live, take, br_taken, alt, is_jalr;
   logic            unused_c;

   assign unused_c = ^{ex_state.func7[6], ex_state.func7[4:0], ex_state.branch};

   // EX/MEM forwarding is only legal for non-load results; loads go through the hazard path
   assign mem_fwd_ok = mem_valid_q && mem_regwrite_q && !mem_mem_read_q && (mem_rd_q != '0);

   assign rs1_fwd = (ex_state.rs1 == '0) ? '0 :
                    (mem_fwd_ok && mem_rd_q == ex_state.rs1) ? mem_alu_result_q :
                    (wb_we && wb_rd != '0 && wb_rd == ex_state.rs1) ? wb_data : rs1_data;
   assign rs2_fwd = (ex_state.rs2 == '0) ? '0 :
                    (mem_fwd_ok && mem_rd_q == ex_state.rs2) ? mem_alu_result_q :
                    (wb_we && wb_rd != '0 && wb_rd == ex_state.rs2) ? wb_data : rs2_data;

   assign op1   = (ex_state.alu_src == 2'b10) ? ex_state.pc : rs1_fwd;
   assign op2   = (ex_state.alu_src == 2'b01 || ex_state.alu_src == 2'b10) ?
                  ex_state.immediate : rs2_fwd;
   assign shamt = op2[4:0];
   assign alt   = ex_state.func7[5];
   assign link  = ex_state.pc + (ex_ilen16 ? XLEN'(2) : XLEN'(4));

   assign hazard = ex_valid && mem_valid_q && mem_mem_read_q && (mem_rd_q != '0) &&
                   (mem_rd_q == ex_state.rs1 || mem_rd_q == ex_state.rs2);
   // The instruction sitting in EX during a redirect cycle is wrong-path
   assign kill     = redirect_valid_q;
   assign live     = ex_valid && !kill && !hazard;
   assign ex_stall = !rst && (mem_stall || (hazard && !kill));

   assign is_jalr = (ex_state.alu_src == 2'b01);
   assign target  = (ex_state.alu_op == 3'd6 && is_jalr) ?
                    ((rs1_fwd + ex_state.immediate) & ~XLEN'(1)) :
                    (ex_state.pc + ex_state.immediate);
   assign take    = (ex_state.alu_op == 3'd3 && br_taken) || (ex_state.alu_op == 3'd6);

   always_comb begin
      br_taken = 1'b0;
      case (ex_state.func3)
         3'b000:  br_taken = (rs1_fwd == rs2_fwd);
         3'b001:  br_taken = (rs1_fwd != rs2_fwd);
         3'b100:  br_taken = ($signed(rs1_fwd) <  $signed(rs2_fwd));
         3'b101:  br_taken = ($signed(rs1_fwd) >= $signed(rs2_fwd));
         3'b110:  br_taken = (rs1_fwd <  rs2_fwd);
         3'b111:  br_taken = (rs1_fwd >= rs2_fwd);
         default: br_taken = 1'b0;
      endcase
   end

   always_comb begin
      alu_res = '0;
      case (ex_state.alu_op)
         3'd0, 3'd1: begin
            case (ex_state.func3)
               3'b000:  alu_res = (ex_state.alu_op == 3'd0 && alt) ? op1 - op2 : op1 + op2;
               3'b001:  alu_res = op1 << shamt;
               3'b010:  alu_res = XLEN'($signed(op1) < $signed(op2));
               3'b011:  alu_res = XLEN'(op1 < op2);
               3'b100:  alu_res = op1 ^ op2;
               3'b101:  alu_res = alt ? XLEN'($signed(op1) >>> shamt) : op1 >> shamt;
               3'b110:  alu_res = op1 | op2;
               default: alu_res = op1 & op2;
            endcase
         end
         3'd2:    alu_res = op1 + op2;
         3'd4:    alu_res = ex_state.immediate;
         3'd5:    alu_res = ex_state.pc + ex_state.immediate;
         3'd6:    alu_res = link;
         default: alu_res = '0;
      endcase
   end

   // Next-state: hold on mem_stall, except the one-cycle redirect pulse always drops
   always_comb begin
      mem_valid_d      = mem_valid_q;
      mem_pc_d         = mem_pc_q;
      mem_alu_result_d = mem_alu_result_q;
      mem_store_data_d = mem_store_data_q;
      mem_rd_d         = mem_rd_q;
      mem_func3_d      = mem_func3_q;
      mem_mem_read_d   = mem_mem_read_q;
      mem_mem_write_d  = mem_mem_write_q;
      mem_mem2reg_d    = mem_mem2reg_q;
      mem_regwrite_d   = mem_regwrite_q;
      redirect_valid_d = 1'b0;
      redirect_pc_d    = redirect_pc_q;
      if (!mem_stall) begin
         mem_valid_d      = live;
         mem_pc_d         = ex_state.pc;
         mem_alu_result_d = alu_res;
         mem_store_data_d = rs2_fwd;
         mem_rd_d         = ex_state.rd;
         mem_func3_d      = ex_state.func3;
         mem_mem_read_d   = live && ex_state.mem_read && ex_state.alu_op != 3'd7;
         mem_mem_write_d  = live && ex_state.mem_write && ex_state.alu_op != 3'd7;
         mem_mem2reg_d    = live && ex_state.mem2reg && ex_state.alu_op != 3'd7;
         mem_regwrite_d   = live && ex_state.reg_write && ex_state.rd != '0 &&
                            ex_state.alu_op != 3'd7;
         if (live && take) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = target;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_valid_q      <= 1'b0;
         mem_pc_q         <= RESET_PC;
         mem_alu_result_q <= '0;
         mem_store_data_q <= '0;
         mem_rd_q         <= '0;
         mem_func3_q      <= '0;
         mem_mem_read_q   <= 1'b0;
         mem_mem_write_q  <= 1'b0;
         mem_mem2reg_q    <= 1'b0;
         mem_regwrite_q   <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
      end else begin
         mem_valid_q      <= mem_valid_d;
         mem_pc_q         <= mem_pc_d;
         mem_alu_result_q <= mem_alu_result_d;
         mem_store_data_q <= mem_store_data_d;
         mem_rd_q         <= mem_rd_d;
         mem_func3_q      <= mem_func3_d;
         mem_mem_read_q   <= mem_mem_read_d;
         mem_mem_write_q  <= mem_mem_write_d;
         mem_mem2reg_q    <= mem_mem2reg_d;
         mem_regwrite_q   <= mem_regwrite_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
      end
   end

   assign mem_valid      = mem_valid_q;
   assign mem_pc         = mem_pc_q;
   assign mem_alu_result = mem_alu_result_q;
   assign mem_store_data = mem_store_data_q;
   assign mem_rd         = mem_rd_q;
   assign mem_func3      = mem_func3_q;
   assign mem_mem_read   = mem_mem_read_q;
   assign mem_mem_write  = mem_mem_write_q;
   assign mem_mem2reg    = mem_mem2reg_q;
   assign mem_regwrite   = mem_regwrite_q;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: forwarding, load-use, branches, jumps,
// x0 handling, mem_stall hold and asynchronous reset.
module tb_ex_stage;
   import ex_stage_pkg::*;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clk, rst, ex_valid, ex_ilen16, wb_we, mem_stall;
   ex_state_t   st;
   logic [31:0] rs1d, rs2d, wb_data;
   logic [4:0]  wb_rd;
   logic        ex_stall, redirect_valid, mem_valid, mem_mem_read, mem_mem_write;
   logic        mem_mem2reg, mem_regwrite;
   logic [31:0] redirect_pc, mem_pc, mem_alu_result, mem_store_data;
   logic [4:0]  mem_rd;
   logic [2:0]  mem_func3;
   int          checks, errors;

   ex_stage #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_state(st), .ex_ilen16(ex_ilen16),
      .rs1_data(rs1d), .rs2_data(rs2d), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .mem_stall(mem_stall), .ex_stall(ex_stall), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .mem_valid(mem_valid), .mem_pc(mem_pc),
      .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data), .mem_rd(mem_rd),
      .mem_func3(mem_func3), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
      .mem_mem2reg(mem_mem2reg), .mem_regwrite(mem_regwrite));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic ex_state_t mk(input logic [31:0] pc, input logic [2:0] aop,
                                    input logic [1:0] src, input logic [2:0] f3,
                                    input logic [6:0] f7, input logic [31:0] imm,
                                    input logic [4:0] rd, input logic [4:0] r1,
                                    input logic [4:0] r2, input logic rw, input logic ld);
      ex_state_t s;
      s           = '0;
      s.pc        = pc;
      s.alu_op    = aop;
      s.alu_src   = src;
      s.func3     = f3;
      s.func7     = f7;
      s.immediate = imm;
      s.rd        = rd;
      s.rs1       = r1;
      s.rs2       = r2;
      s.reg_write = rw;
      s.mem_read  = ld;
      s.mem2reg   = ld;
      s.branch    = (aop == 3'd3);
      return s;
   endfunction

   task automatic test_reset();
      tick();
      tick();
      checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_valid got %h exp 0", mem_valid); end
      checks++; if (mem_pc !== RST_PC) begin errors++; $display("FAIL rst_mem_pc got %h exp %h", mem_pc, RST_PC); end
      checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL rst_redirect_valid got %h exp 0", redirect_valid); end
      checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL rst_redirect_pc got %h exp 0", redirect_pc); end
      checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL rst_ex_stall got %h exp 0", ex_stall); end
      checks++; if (mem_regwrite !== 1'b0) begin errors++; $display("FAIL rst_regwrite got %h exp 0", mem_regwrite); end
      rst = 1'b0;
      mem_stall = 1'b0;
   endtask

   task automatic test_forward();
      ex_valid = 1'b1;
      st = mk(32'h10, 3'd0, 2'b00, 3'b000, 7'h00, 32'h0, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0);
      rs1d = 32'd5; rs2d = 32'd7;
      tick();
      checks++; if (mem_alu_result !== 32'd12) begin errors++; $display("FAIL add_result got %h exp %h", mem_alu_result, 32'd12); end
      checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %h exp 1", mem_valid); end
      checks++; if (mem_rd !== 5'd3 || mem_regwrite !== 1'b1) begin errors++; $display("FAIL add_rd got rd %0d rw %h exp rd 3 rw 1", mem_rd, mem_regwrite); end
      st = mk(32'h14, 3'd0, 2'b00, 3'b000, 7'h20, 32'h0, 5'd4, 5'd3, 5'd1, 1'b1, 1'b0);
      rs1d = 32'hBAD; rs2d = 32'd5;
      tick();
      checks++; if (mem_alu_result !== 32'd7) begin errors++; $display("FAIL sub_fwd_result got %h exp %h", mem_alu_result, 32'd7); end
      checks++; if (mem_store_data !== 32'd5) begin errors++; $display("FAIL sub_store_data got %h exp %h", mem_store_data, 32'd5); end
   endtask

   task automatic test_load_use();
      st = mk(32'h18, 3'd2, 2'b01, 3'b010, 7'h00, 32'h4, 5'd5, 5'd1, 5'd0, 1'b1, 1'b1);
      rs1d = 32'h100; rs2d = 32'h0;
      tick();
      checks++; if (mem_alu_result !== 32'h104 || mem_mem_read !== 1'b1) begin errors++; $display("FAIL lw_addr got %h rd %h exp 104 rd 1", mem_alu_result, mem_mem_read); end
      st = mk(32'h1C, 3'd0, 2'b00, 3'b000, 7'h00, 32'h0, 5'd6, 5'd5, 5'd5, 1'b1, 1'b0);
      rs1d = 32'hDEAD; rs2d = 32'hDEAD;
      #1;
      checks++; if (ex_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %h exp 1", ex_stall); end
      tick();
      checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got %h exp 0", mem_valid); end
      checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL lu_stall_clear got %h exp 0", ex_stall); end
      wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h10;
      tick();
      checks++; if (mem_alu_result !== 32'h20 || mem_valid !== 1'b1) begin errors++; $display("FAIL lu_wb_fwd got %h v %h exp 20 v 1", mem_alu_result, mem_valid); end
      wb_we = 1'b0;
   endtask

   task automatic test_branch();
      st = mk(32'h100, 3'd3, 2'b00, 3'b000, 7'h00, 32'h20, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);
      rs1d = 32'd9; rs2d = 32'd9;
      tick();
      checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h120) begin errors++; $display("FAIL beq_taken got v %h pc %h exp v 1 pc 120", redirect_valid, redirect_pc); end
      st = mk(32'h104, 3'd0, 2'b00, 3'b000, 7'h00, 32'h0, 5'd8, 5'd1, 5'd2, 1'b1, 1'b0);
      tick();
      checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL beq_kill got %h exp 0", mem_valid); end
      checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL beq_one_cycle got %h exp 0", redirect_valid); end
      st = mk(32'h100, 3'd3, 2'b00, 3'b000, 7'h00, 32'h20, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);
      rs2d = 32'd8;
      tick();
      checks++; if (redirect_valid !== 1'b0 || mem_valid !== 1'b1) begin errors++; $display("FAIL beq_not_taken got rv %h mv %h exp rv 0 mv 1", redirect_valid, mem_valid); end
   endtask

   task automatic test_jump();
      ex_ilen16 = 1'b1;
      st = mk(32'h200, 3'd6, 2'b10, 3'b000, 7'h00, 32'h40, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0);
      tick();
      checks++; if (mem_alu_result !== 32'h202) begin errors++; $display("FAIL cjal_link got %h exp 202", mem_alu_result); end
      checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h240) begin errors++; $display("FAIL cjal_target got v %h pc %h exp v 1 pc 240", redirect_valid, redirect_pc); end
      ex_ilen16 = 1'b0; ex_valid = 1'b0;
      tick();
      ex_valid = 1'b1;
      st = mk(32'h210, 3'd6, 2'b01, 3'b000, 7'h00, 32'h0, 5'd1, 5'd7, 5'd0, 1'b1, 1'b0);
      rs1d = 32'h301;
      tick();
      checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h300) begin errors++; $display("FAIL jalr_target got v %h pc %h exp v 1 pc 300", redirect_valid, redirect_pc); end
      checks++; if (mem_alu_result !== 32'h214) begin errors++; $display("FAIL jalr_link got %h exp 214", mem_alu_result); end
      ex_valid = 1'b0;
      tick();
   endtask

   task automatic test_x0_compare();
      ex_valid = 1'b1;
      st = mk(32'h220, 3'd1, 2'b01, 3'b000, 7'h00, 32'h1, 5'd0, 5'd1, 5'd0, 1'b1, 1'b0);
      rs1d = 32'd5;
      tick();
      checks++; if (mem_regwrite !== 1'b0 || mem_alu_result !== 32'd6) begin errors++; $display("FAIL addi_x0 got rw %h res %h exp rw 0 res 6", mem_regwrite, mem_alu_result); end
      st = mk(32'h300, 3'd3, 2'b00, 3'b110, 7'h00, 32'hFFFF_FFF8, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);
      rs1d = 32'hFFFF_FFFF; rs2d = 32'd1;
      tick();
      checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL bltu_not_taken got %h exp 0", redirect_valid); end
      st.func3 = 3'b100;
      tick();
      checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h2F8) begin errors++; $display("FAIL blt_taken got v %h pc %h exp v 1 pc 2f8", redirect_valid, redirect_pc); end
      ex_valid = 1'b0;
      tick();
      ex_valid = 1'b1;
      st = mk(32'h308, 3'd1, 2'b01, 3'b101, 7'h20, 32'h404, 5'd9, 5'd1, 5'd0, 1'b1, 1'b0);
      rs1d = 32'h8000_0000;
      tick();
      checks++; if (mem_alu_result !== 32'hF800_0000) begin errors++; $display("FAIL srai got %h exp f8000000", mem_alu_result); end
   endtask

   task automatic test_mem_stall();
      st = mk(32'h400, 3'd6, 2'b10, 3'b000, 7'h00, 32'h10, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      tick();
      checks++; if (redirect_valid !== 1'b1 || mem_alu_result !== 32'h404) begin errors++; $display("FAIL jal_pre_stall got v %h res %h exp v 1 res 404", redirect_valid, mem_alu_result); end
      mem_stall = 1'b1;
      st = mk(32'h500, 3'd0, 2'b00, 3'b000, 7'h00, 32'h0, 5'd10, 5'd1, 5'd2, 1'b1, 1'b0);
      rs1d = 32'd3; rs2d = 32'd4;
      #1;
      checks++; if (ex_stall !== 1'b1) begin errors++; $display("FAIL stall_ex_stall got %h exp 1", ex_stall); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (mem_alu_result !== 32'h404 || mem_pc !== 32'h400 || mem_valid !== 1'b1) begin errors++; $display("FAIL stall_hold_%0d got res %h pc %h v %h exp 404 400 1", i, mem_alu_result, mem_pc, mem_valid); end
         checks++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h410) begin errors++; $display("FAIL stall_redirect_%0d got v %h pc %h exp v 0 pc 410", i, redirect_valid, redirect_pc); end
      end
      mem_stall = 1'b0;
      tick();
      checks++; if (mem_alu_result !== 32'd7 || mem_pc !== 32'h500 || mem_valid !== 1'b1) begin errors++; $display("FAIL stall_release got res %h pc %h v %h exp 7 500 1", mem_alu_result, mem_pc, mem_valid); end
   endtask

   task automatic test_reset_mid();
      mem_stall = 1'b1;
      rst = 1'b1;
      #1;
      checks++; if (mem_valid !== 1'b0 || mem_pc !== RST_PC) begin errors++; $display("FAIL arst_mem got v %h pc %h exp v 0 pc %h", mem_valid, mem_pc, RST_PC); end
      checks++; if (mem_alu_result !== 32'h0 || redirect_pc !== 32'h0) begin errors++; $display("FAIL arst_data got res %h rpc %h exp 0 0", mem_alu_result, redirect_pc); end
      checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL arst_ex_stall got %h exp 0", ex_stall); end
      tick();
      rst = 1'b0;
      mem_stall = 1'b0;
      ex_valid = 1'b0;
   endtask

   initial begin
      checks = 0; errors = 0;
      rst = 1'b1; ex_valid = 1'b0; st = '0; ex_ilen16 = 1'b0;
      rs1d = '0; rs2d = '0; wb_we = 1'b0; wb_rd = '0; wb_data = '0; mem_stall = 1'b1;
      test_reset();
      test_forward();
      test_load_use();
      test_branch();
      test_jump();
      test_x0_compare();
      test_mem_stall();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the RV32IC pipeline. It consumes the ID/EX pipeline record `EX_STATE`, which decode produces, and applies forwarding to the register-file operands. It computes the ALU result and resolves branches and jumps, then registers the results into the EX/MEM record for the memory stage. It also detects load-use hazards and issues a registered redirect that flushes the front end.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: value held in `mem_pc` after reset.

Ports (all outputs are registered):
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ex_valid` in 1: `ex_state` holds a live instruction.
- `ex_state` in `$bits(EX_STATE)` (99): ID/EX record. Fields: pc, func3, func7, ALUOp, immediate, rd, ALUsrc, Mem2Reg, RegWrite, branch, rs1, rs2, MemRead, MemWrite.
- `ex_ilen16` in 1: the instruction is compressed, so the link value is pc+2.
- `rs1_data`, `rs2_data` in 32 each: synchronous register-file read data.
- `wb_we` in 1, `wb_rd` in 5, `wb_data` in 32: write-back forwarding source.
- `mem_stall` in 1: the memory stage cannot accept; everything holds.
- `ex_stall` out 1: decode must hold `ex_state`. This signal is combinational and is the only unregistered output.
- `redirect_valid` out 1, `redirect_pc` out 32: taken branch or jump.
- `mem_valid`, `mem_pc`, `mem_alu_result`, `mem_store_data`, `mem_rd`, `mem_func3`, `mem_mem_read`, `mem_mem_write`, `mem_mem2reg`, `mem_regwrite`: EX/MEM record.

## Operation
ALUOp encoding:
- 0: R-type, selected by func3/func7[5].
- 1: I-type arithmetic. func7[5] is used only for SRAI.
- 2: address add.
- 3: conditional branch.
- 4: LUI (result = imm).
- 5: AUIPC.
- 6: JAL/JALR.
- 7: reserved; the result is 0 and the instruction is otherwise treated as a NOP.

ALUsrc encoding:
- 00: op1=rs1, op2=rs2.
- 01: op1=rs1, op2=imm.
- 10: op1=pc, op2=imm.
- 11: same as 00.

Forwarding, applied per operand in priority order:
- The EX/MEM register, when `mem_valid`, `mem_regwrite`, `!mem_mem_read`, `mem_rd!=0` and `mem_rd` matches the source register.
- Otherwise WB, when `wb_we`, `wb_rd!=0` and `wb_rd` matches.
- Otherwise the register-file data.
- rs=0 always reads 0.

Load-use hazard:
- A hazard exists when `ex_valid`, `mem_valid`, `mem_mem_read`, `mem_rd!=0` and `mem_rd` equals rs1 or rs2.
- On a hazard: `ex_stall=1` and a bubble (`mem_valid=0`) is written to EX/MEM. The next cycle resolves the hazard through WB forwarding.

Branches (ALUOp 3):
- func3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- Target = pc+imm.
- func3 010/011 are never taken.

Jumps (ALUOp 6):
- ALUsrc=10: JAL, target = pc+imm.
- ALUsrc=01: JALR, target = (rs1+imm)&~1.
- Result = pc+2 when `ex_ilen16`, otherwise pc+4.

Results and side effects:
- Store data = forwarded rs2.
- `mem_regwrite` is forced to 0 when rd=0.
- On a taken branch or jump, the next edge sets `redirect_valid=1` and `redirect_pc=target` for exactly one cycle.
- In that same redirect cycle, the instruction in EX is on the wrong path. It is killed: a bubble goes to MEM and no further redirect is raised.
- Arithmetic is 32-bit modulo. Shifts use op2[4:0]; SRA sign-extends.

## Timing
- Reset values: all `mem_*`=0 except `mem_pc=RESET_PC`; `redirect_valid=0`; `redirect_pc=0`. `ex_stall` is 0 while in reset.
- Latency: one cycle from `ex_state` to the EX/MEM record and to the redirect.
- When `mem_stall=1`, the EX/MEM and redirect registers hold their values and `ex_stall=1`. A pending one-cycle `redirect_valid` is still cleared after one cycle; decode must register it.
- Simultaneous load-use hazard and redirect kill: the kill wins, giving a bubble with no stall.
- Reset asserted mid-operation clears the state immediately, without waiting for a clock edge.

## Test plan
- ADD x3,x1,x2 with x1=5 and x2=7, followed by SUB x4,x3,x1 → `mem_alu_result` is 12 and then 7, with the EX/MEM forward used.
- LW x5 followed by ADD x6,x5,x5 → `ex_stall=1` for one cycle, one bubble, then the ADD uses `wb_data`=0x10 and produces 0x20.
- BEQ at pc 0x100 with imm=0x20 and equal operands → `redirect_pc=0x120` for one cycle and the following instruction is bubbled. With unequal operands → no redirect.
- C.JAL (`ex_ilen16=1`) at 0x200 → result 0x202. JALR with rs1=0x301 and imm=0 → target 0x300.
- ADDI x0,x1,1 → `mem_regwrite=0`. BLTU with 0xFFFF_FFFF vs 1 is not taken; BLT with the same operands is taken.
- `mem_stall` held for 3 cycles → EX/MEM is unchanged. `rst` asserted mid-stream → all outputs take their reset values before the next clock edge.
